// File: rtl/diod_scan_controller_pkg.sv
// Shared definitions for the diode scan controller.
// FSM encoding, SPI frame width and SPI mode.
package diod_scan_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_SPI = 3'd2,
        ST_MEASURE  = 3'd3,
        ST_DECIDE   = 3'd4,
        ST_REPORT   = 3'd5,
        ST_FINISH   = 3'd6
    } state_t;

    // SPI mode 0: clock idles low, data sampled on rising edge
    localparam logic [1:0] SPI_MODE = 2'd0;

    // Frame carries the channel index followed by the voltage code
    function automatic int frame_width(input int nch, input int vw);
        return $clog2(nch) + vw;
    endfunction

endpackage

// File: rtl/diod_spi_frame_master.sv
// SPI frame master, MSB first, parametrised frame length.
// Half-period of CLK_DIV cycles; select rises CLK_DIV after last falling edge.
module diod_spi_frame_master
    import diod_scan_controller_pkg::*;
#(
    parameter int FRAME   = 12,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [FRAME-1:0] data,
    output logic             mosi,
    output logic             sclk,
    output logic             ss,
    output logic             done
);

    localparam int DW  = $clog2(CLK_DIV + 1);
    localparam int HCW = $clog2(2 * FRAME + 2);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HCW-1:0] HALF_END = HCW'(2 * FRAME + 1);
    localparam logic           CPOL     = SPI_MODE[1];

    logic             active;
    logic [DW-1:0]    div;
    logic [HCW-1:0]   half;
    logic [HCW-1:0]   half_nx;
    logic [FRAME-1:0] shreg;

    assign half_nx = half + 1'b1;
    // Shift register empties itself, so MOSI returns low between frames
    assign mosi    = shreg[FRAME-1];

    // Half-period sequencer: odd halves raise SCLK, even halves fall and shift
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            div    <= '0;
            half   <= '0;
            shreg  <= '0;
            sclk   <= CPOL;
            ss     <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active <= 1'b1;
                    ss     <= 1'b0;
                    sclk   <= CPOL;
                    div    <= '0;
                    half   <= '0;
                    shreg  <= data;
                end
            end else if (div != DIV_LAST) begin
                div <= div + 1'b1;
            end else begin
                div  <= '0;
                half <= half_nx;
                if (half_nx == HALF_END) begin
                    active <= 1'b0;
                    ss     <= 1'b1;
                    sclk   <= CPOL;
                    done   <= 1'b1;
                end else if (half_nx[0]) begin
                    sclk <= ~CPOL;
                end else begin
                    sclk  <= CPOL;
                    shreg <= shreg << 1;
                end
            end
        end
    end

endmodule

// File: rtl/diod_scan_controller.sv
// Multi-channel diode bias scan controller.
// Ramps a DAC code per channel until noise hits reach threshold.
module diod_scan_controller
    import diod_scan_controller_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int VW         = 8,
    parameter int WIN_LEN    = 256,
    parameter int HIT_THRESH = 2,
    parameter int CLK_DIV    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NCH-1:0]           noise_valid,
    output logic                     spi_mosi,
    output logic                     spi_clk,
    output logic                     spi_ss,
    output logic                     busy,
    output logic                     done,
    output logic                     result_valid,
    output logic [$clog2(NCH)-1:0]   result_ch,
    output logic [VW-1:0]            result_voltage,
    output logic                     result_sat,
    output logic [2:0]               debug_state
);

    localparam int CHW   = $clog2(NCH);
    localparam int FRAME = frame_width(NCH, VW);
    localparam int HW    = $clog2(WIN_LEN + 1);
    localparam int WW    = $clog2(WIN_LEN + 1);

    localparam logic [HW-1:0]  THRESH   = HW'(HIT_THRESH);
    localparam logic [HW-1:0]  HIT_MAX  = '1;
    localparam logic [WW-1:0]  WIN_LAST = WW'(WIN_LEN - 1);
    localparam logic [VW-1:0]  V_MAX    = '1;
    localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CHW-1:0]   ch;
    logic [VW-1:0]    v;
    logic [WW-1:0]    win;
    logic [HW-1:0]    hits;
    logic             hit;
    logic             at_max;
    logic             spi_start;
    logic             spi_done;
    logic [FRAME-1:0] spi_data;

    assign hit          = hits >= THRESH;
    assign at_max       = v == V_MAX;
    assign spi_start    = state == ST_SEND;
    assign spi_data     = {ch, v};
    assign busy         = (state != ST_IDLE) && (state != ST_FINISH);
    assign done         = state == ST_FINISH;
    assign result_valid = state == ST_REPORT;
    assign debug_state  = state;

    diod_spi_frame_master #(
        .FRAME   (FRAME),
        .CLK_DIV (CLK_DIV)
    ) u_spi (
        .clk   (clk),
        .reset (reset),
        .start (spi_start),
        .data  (spi_data),
        .mosi  (spi_mosi),
        .sclk  (spi_clk),
        .ss    (spi_ss),
        .done  (spi_done)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (start) state_nx = ST_SEND;
            ST_SEND:     state_nx = ST_WAIT_SPI;
            ST_WAIT_SPI: if (spi_done) state_nx = ST_MEASURE;
            ST_MEASURE:  if (win == WIN_LAST) state_nx = ST_DECIDE;
            ST_DECIDE:   state_nx = (hit || at_max) ? ST_REPORT : ST_SEND;
            ST_REPORT:   state_nx = (ch == CH_LAST) ? ST_FINISH : ST_SEND;
            ST_FINISH:   state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Channel/code stepping, window counting and result latching
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch             <= '0;
            v              <= '0;
            win            <= '0;
            hits           <= '0;
            result_ch      <= '0;
            result_voltage <= '0;
            result_sat     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ch <= '0;
                        v  <= '0;
                    end
                end
                ST_WAIT_SPI: begin
                    if (spi_done) begin
                        win  <= '0;
                        hits <= '0;
                    end
                end
                ST_MEASURE: begin
                    win <= win + 1'b1;
                    if (noise_valid[ch] && hits != HIT_MAX) hits <= hits + 1'b1;
                end
                ST_DECIDE: begin
                    if (hit || at_max) begin
                        result_ch      <= ch;
                        result_voltage <= v;
                        result_sat     <= !hit;
                    end else begin
                        v <= v + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (ch != CH_LAST) begin
                        ch <= ch + 1'b1;
                        v  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_diod_scan_controller.sv
// Bench for diod_scan_controller: SPI frame decoding and result scoreboard.
// Directed runs: detection, saturation, threshold edge, busy start, reset abort.
module tb_diod_scan_controller;
    import diod_scan_controller_pkg::*;

    localparam int NCH        = 2;
    localparam int VW         = 4;
    localparam int WIN_LEN    = 8;
    localparam int HIT_THRESH = 2;
    localparam int CLK_DIV    = 2;
    localparam int FRAME      = 5;
    localparam int SS_LOW     = 2 * CLK_DIV * FRAME + CLK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] noise_valid = 2'b00;
    logic       spi_mosi;
    logic       spi_clk;
    logic       spi_ss;
    logic       busy;
    logic       done;
    logic       result_valid;
    logic       result_ch;
    logic [3:0] result_voltage;
    logic       result_sat;
    logic [2:0] debug_state;

    diod_scan_controller #(
        .NCH        (NCH),
        .VW         (VW),
        .WIN_LEN    (WIN_LEN),
        .HIT_THRESH (HIT_THRESH),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .noise_valid    (noise_valid),
        .spi_mosi       (spi_mosi),
        .spi_clk        (spi_clk),
        .spi_ss         (spi_ss),
        .busy           (busy),
        .done           (done),
        .result_valid   (result_valid),
        .result_ch      (result_ch),
        .result_voltage (result_voltage),
        .result_sat     (result_sat),
        .debug_state    (debug_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [4:0] frame_q[$];
    logic [5:0] res_q[$];

    int         mode = 0;
    logic [4:0] last_code = '0;
    int         mcnt = 0;
    int         done_count = 0;
    int         idle_clk_err = 0;
    int         frames_seen = 0;
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Noise stimulus; mcnt indexes the current MEASURE cycle
    always @(negedge clk) begin
        int idx;
        idx = mcnt;
        if (debug_state == ST_MEASURE) mcnt++;
        else mcnt = 0;
        case (mode)
            1: noise_valid = {last_code[3:0] >= 4'd9, 1'b1};
            2: noise_valid = (debug_state == ST_MEASURE &&
                              (idx == 0 || (idx == 3 && last_code[3:0] == 4'd3)))
                             ? 2'b11 : 2'b00;
            default: noise_valid = 2'b00;
        endcase
    end

    // SPI receiver and frame timing checker
    int         low_cnt = 0;
    int         n_rise = 0;
    int         last_rise = 0;
    logic       prev_ss = 1'b1;
    logic       prev_sclk = 1'b0;
    logic       prev_mosi = 1'b0;
    logic       in_frame = 1'b0;
    logic [4:0] rx = '0;

    always @(negedge clk) begin
        logic [4:0] e;
        if (!reset) begin
            in_frame  = 1'b0;
            prev_ss   = 1'b1;
            prev_sclk = 1'b0;
        end else begin
            if (spi_ss && spi_clk) idle_clk_err++;
            if (prev_ss && !spi_ss) begin
                in_frame  = 1'b1;
                low_cnt   = 0;
                n_rise    = 0;
                rx        = '0;
                prev_mosi = spi_mosi;
            end
            if (!spi_ss && in_frame) begin
                low_cnt++;
                if (!prev_sclk && spi_clk) begin
                    if (n_rise > 0) check("rise_gap", cyc - last_rise, 2 * CLK_DIV);
                    check("mosi_stable", spi_mosi, prev_mosi);
                    rx = {rx[3:0], spi_mosi};
                    n_rise++;
                    last_rise = cyc;
                end
            end
            if (!prev_ss && spi_ss && in_frame) begin
                in_frame = 1'b0;
                frames_seen++;
                check("ss_low", low_cnt, SS_LOW);
                check("rises", n_rise, FRAME);
                if (frame_q.size() == 0) begin
                    check("frame_extra", frame_q.size(), 1);
                end else begin
                    e = frame_q.pop_front();
                    check("frame", rx, e);
                end
                last_code = rx;
            end
            prev_ss   = spi_ss;
            prev_sclk = spi_clk;
            prev_mosi = spi_mosi;
        end
        cyc++;
    end

    // Result scoreboard
    always @(negedge clk) begin
        logic [5:0] e;
        if (reset && result_valid) begin
            if (res_q.size() == 0) begin
                check("result_extra", res_q.size(), 1);
            end else begin
                e = res_q.pop_front();
                check("result", {result_ch, result_voltage, result_sat}, e);
            end
        end
        if (reset && done) done_count++;
    end

    task automatic push_frames(input logic c, input int last);
        for (int i = 0; i <= last; i++) frame_q.push_back({c, 4'(i)});
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_rise", busy, 1);
        check("state_send", debug_state, ST_SEND);
    endtask

    task automatic wait_done(input int base, input int budget);
        int c;
        c = 0;
        while (done_count == base && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        check("done_once", done_count - base, 1);
        check("frames_left", frame_q.size(), 0);
        check("results_left", res_q.size(), 0);
        check("busy_idle", busy, 0);
        check("state_idle", debug_state, ST_IDLE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c;

        // Reset held with start pulses
        repeat (3) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        check("rst_ss", spi_ss, 1);
        check("rst_sclk", spi_clk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rv", result_valid, 0);
        check("rst_rch", result_ch, 0);
        check("rst_rv_code", result_voltage, 0);
        check("rst_sat", result_sat, 0);
        check("rst_state", debug_state, ST_IDLE);
        check("rst_frames", frames_seen, 0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);

        // Detection: ch0 immediate, ch1 at code 9; a start while busy is ignored
        mode = 1;
        push_frames(1'b0, 0);
        push_frames(1'b1, 9);
        res_q.push_back({1'b0, 4'd0, 1'b0});
        res_q.push_back({1'b1, 4'd9, 1'b0});
        base = done_count;
        pulse_start();
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(base, 2000);

        // No noise: both channels saturate at code 15
        mode = 0;
        push_frames(1'b0, 15);
        push_frames(1'b1, 15);
        res_q.push_back({1'b0, 4'd15, 1'b1});
        res_q.push_back({1'b1, 4'd15, 1'b1});
        base = done_count;
        pulse_start();
        wait_done(base, 3000);

        // Threshold edge: one hit per window misses, two at code 3 detect
        mode = 2;
        push_frames(1'b0, 3);
        push_frames(1'b1, 3);
        res_q.push_back({1'b0, 4'd3, 1'b0});
        res_q.push_back({1'b1, 4'd3, 1'b0});
        base = done_count;
        pulse_start();
        wait_done(base, 1000);

        // Reset in the middle of a frame
        mode = 0;
        push_frames(1'b0, 15);
        pulse_start();
        c = 0;
        while (spi_clk !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("sclk_seen", spi_clk, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_ss", spi_ss, 1);
        check("abort_sclk", spi_clk, 0);
        check("abort_mosi", spi_mosi, 0);
        check("abort_busy", busy, 0);
        check("abort_state", debug_state, ST_IDLE);
        check("abort_rcode", result_voltage, 0);
        frame_q.delete();
        res_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Restart after abort begins again at ch0, code 0
        mode = 2;
        push_frames(1'b0, 3);
        push_frames(1'b1, 3);
        res_q.push_back({1'b0, 4'd3, 1'b0});
        res_q.push_back({1'b1, 4'd3, 1'b0});
        base = done_count;
        pulse_start();
        wait_done(base, 1000);

        check("idle_sclk", idle_clk_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
